// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   Assembles little-endian 32-bit words from a UART byte stream and writes
//   them into instruction memory. The core is held in reset (cpu_rst) until
//   the end-of-program marker word arrives.
//
// Ports
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   rx_valid     in   one-cycle strobe, rx_data holds a received byte
//   rx_data      in   [7:0] received byte
//   rx_break     in   UART BREAK: discard the partially assembled word
//   reload       in   one-cycle request to restart loading from address 0
//   imem_wr_en   out  one-cycle memory write strobe
//   imem_wr_addr out  [ADDR_W-1:0] word address of the write
//   imem_wr_data out  [31:0] word to write
//   cpu_rst      out  high while loading
//   write_done   out  high once the end marker has been received
//   overflow     out  sticky: a word was dropped because memory was full
//   words_loaded out  [ADDR_W:0] words written since the last load start
module uart_imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = 32'hFFFFFFFF,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  input  logic              reload,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rst,
  output logic              write_done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0]   WORD_ONE  = 1;

  typedef enum logic {LOAD, DONE} state_t;

  state_t              state_reg,        state_next;
  logic [1:0]          byte_cnt_reg,     byte_cnt_next;
  logic [23:0]         word_reg,         word_next;   // bytes 0..2; byte 3 comes straight from rx_data
  logic [IDLE_W-1:0]   idle_cnt_reg,     idle_cnt_next;
  logic                wr_en_reg,        wr_en_next;
  logic [ADDR_W-1:0]   wr_addr_reg,      wr_addr_next;
  logic [31:0]         wr_data_reg,      wr_data_next;
  logic [ADDR_W:0]     words_loaded_reg, words_loaded_next;
  logic                overflow_reg,     overflow_next;
  logic [31:0]         assembled;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= LOAD;
      byte_cnt_reg     <= '0;
      word_reg         <= '0;
      idle_cnt_reg     <= '0;
      wr_en_reg        <= 1'b0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      words_loaded_reg <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      byte_cnt_reg     <= byte_cnt_next;
      word_reg         <= word_next;
      idle_cnt_reg     <= idle_cnt_next;
      wr_en_reg        <= wr_en_next;
      wr_addr_reg      <= wr_addr_next;
      wr_data_reg      <= wr_data_next;
      words_loaded_reg <= words_loaded_next;
      overflow_reg     <= overflow_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    byte_cnt_next     = byte_cnt_reg;
    word_next         = word_reg;
    idle_cnt_next     = idle_cnt_reg;
    wr_en_next        = 1'b0;           // strobe lasts exactly one cycle
    wr_addr_next      = wr_addr_reg;
    wr_data_next      = wr_data_reg;
    words_loaded_next = words_loaded_reg;
    overflow_next     = overflow_reg;
    assembled         = {rx_data, word_reg};

    if (reload) begin
      // Reload outranks everything, including a fourth byte in this cycle.
      state_next        = LOAD;
      byte_cnt_next     = '0;
      word_next         = '0;
      idle_cnt_next     = '0;
      words_loaded_next = '0;
      overflow_next     = 1'b0;
    end else if (state_reg == LOAD) begin
      if (rx_break) begin
        // Break wins over a simultaneous byte; that byte is discarded too.
        byte_cnt_next = '0;
        word_next     = '0;
        idle_cnt_next = '0;
      end else if (rx_valid) begin
        idle_cnt_next = '0;
        byte_cnt_next = byte_cnt_reg + 2'd1;
        case (byte_cnt_reg)
          2'd0: word_next[7:0]   = rx_data;
          2'd1: word_next[15:8]  = rx_data;
          2'd2: word_next[23:16] = rx_data;
          default: begin
            word_next = '0;
            if (assembled == END_WORD) begin
              state_next = DONE;
            end else if (!words_loaded_reg[ADDR_W]) begin
              // MSB clear means fewer than 2^ADDR_W words stored so far.
              wr_en_next        = 1'b1;
              wr_addr_next      = words_loaded_reg[ADDR_W-1:0];
              wr_data_next      = assembled;
              words_loaded_next = words_loaded_reg + WORD_ONE;
            end else begin
              overflow_next = 1'b1;
            end
          end
        endcase
      end else if (byte_cnt_reg != 2'd0) begin
        // Idle timer only runs while a word is partially assembled.
        if (idle_cnt_reg == IDLE_LAST) begin
          byte_cnt_next = '0;
          word_next     = '0;
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = idle_cnt_reg + IDLE_ONE;
        end
      end
    end
  end

  assign imem_wr_en   = wr_en_reg;
  assign imem_wr_addr = wr_addr_reg;
  assign imem_wr_data = wr_data_reg;
  assign cpu_rst      = (state_reg == LOAD);
  assign write_done   = (state_reg == DONE);
  assign overflow     = overflow_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 Parameter END_WORD, default 32'hFFFFFFFF: end-of-program marker word.
REQ-003 Parameter TIMEOUT_CYC, default 50000: idle clk cycles after which a partial word is discarded.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data holds a received UART byte.
REQ-007 rx_data  in  8  received byte.
REQ-008 rx_break  in  1  UART BREAK detected.
REQ-009 reload  in  1  one-cycle request to restart loading from address 0.
REQ-010 imem_wr_en  out  1  one-cycle instruction-memory write strobe.
REQ-011 imem_wr_addr  out  ADDR_W  word address of the write.
REQ-012 imem_wr_data  out  32  word to write.
REQ-013 cpu_rst  out  1  active-high; holds the core in reset while loading.
REQ-014 write_done  out  1  program load complete.
REQ-015 overflow  out  1  sticky; at least one word was dropped because memory was full.
REQ-016 words_loaded  out  ADDR_W+1  count of words written since the last load start.

Function
REQ-017 The block SHALL have states LOAD and DONE.
REQ-018 In LOAD, each rx_valid byte SHALL be placed little-endian into the assembly word: byte 0 into [7:0], byte 1 into [15:8], byte 2 into [23:16], byte 3 into [31:24].
REQ-019 A 2-bit byte counter SHALL count 0..3 and wrap to 0 on the fourth byte.
REQ-020 On the fourth byte, if the assembled word equals END_WORD, the block SHALL enter DONE on the next edge, with no memory write.
REQ-021 On the fourth byte of any other word, with words_loaded < 2^ADDR_W, the block SHALL on the next cycle:
- drive imem_wr_en=1 for exactly one cycle;
- drive imem_wr_addr = words_loaded[ADDR_W-1:0];
- drive imem_wr_data = the assembled word;
- increment words_loaded.
REQ-022 On the fourth byte of a non-END word with words_loaded = 2^ADDR_W, the block SHALL drop the word, suppress imem_wr_en and set overflow.
REQ-023 A byte arriving in the cycle imem_wr_en is high SHALL be accepted as byte 0 of the next word; back-to-back rx_valid on consecutive cycles SHALL lose no byte.
REQ-024 rx_break=1 in LOAD SHALL clear the byte counter and discard the partial word; words already written are unaffected.
REQ-025 Idle timeout:
- An idle counter SHALL reset on every rx_valid.
- When the byte counter is nonzero and the idle counter reaches TIMEOUT_CYC, the byte counter SHALL clear.
- The idle counter SHALL not advance when the byte counter is 0.
REQ-026 rx_valid and rx_break in the same cycle: the break SHALL win and the byte is discarded.
REQ-027 cpu_rst SHALL be 1 in LOAD and 0 in DONE.
REQ-028 write_done SHALL be 0 in LOAD and 1 in DONE.
REQ-029 In DONE, rx_valid and rx_break SHALL be ignored; words_loaded and overflow SHALL hold their values.
REQ-030 reload=1 in either state SHALL, on the next edge, force the following: state LOAD, byte counter 0, words_loaded 0, overflow 0, idle counter 0, imem_wr_en 0.
REQ-031 reload SHALL take priority over a simultaneous fourth byte; that word is not written.

Reset
REQ-032 While resetn=0, the block SHALL be held asynchronously at:
- state LOAD;
- cpu_rst=1, write_done=0, imem_wr_en=0;
- imem_wr_addr=0, imem_wr_data=0;
- words_loaded=0, overflow=0;
- byte and idle counters 0.
REQ-033 Deassertion of resetn SHALL take effect at the first following clk edge.
REQ-034 Assertion of resetn mid-word or mid-write SHALL abort immediately; the partial word is lost and no strobe is emitted.

Verification
REQ-035 Byte stream 13,01,01,FD then FF,FF,FF,FF:
- a single imem_wr_en pulse with addr 0, data 32'hFD010113;
- write_done=1 and cpu_rst=0 one cycle after the last byte;
- words_loaded=1.
REQ-036 Stream of 00×8, then 32'h02812623 little-endian, then END_WORD: writes at addr 0, 1, 2 with data 0, 0, 32'h02812623; words_loaded=3.
REQ-037 Bytes 23,26 then rx_break, then 13,01,01,FD: a single write of 32'hFD010113 at addr 0.
REQ-038 Bytes 23,26, then TIMEOUT_CYC idle cycles, then 13,01,01,FD: a single write of 32'hFD010113 at addr 0.
REQ-039 ADDR_W=2, five non-END words then END_WORD: four writes at addr 0..3, the fifth word dropped, overflow=1, words_loaded=4, write_done=1.
REQ-040 Reload scenario:
- In DONE, pulse reload: write_done=0, cpu_rst=1, words_loaded=0 next cycle.
- Reload, then resetn pulsed low mid-word: all outputs at reset values asynchronously.
